// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the operand-hazard controller: per-stage destination tag and select constants.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } stage_tag_t;

    localparam int         FWD_SEL_RF = 0;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // A producer sitting at 'stage' can hand its result over the bypass network.
    function automatic logic tag_ready(input logic is_load, input int stage, input int load_ready);
        return is_load ? (stage >= load_ready) : (stage >= 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage <-> hazard controller bundle: instruction tags in, stall and bypass selects out.
// Latency: hazard_stall/id_fwd_sel combinational, ex_fwd_sel registered (1 cycle).
// Backpressure: hazard_stall holds ID; pipe_stall freezes the controller.
// Ports: master = ID stage side, slave = controller side.
// Optional: FWD_PERF_EN adds stall_count.
interface hazard_forward_ctrl_if #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 3,
    parameter int SELW       = $clog2(FWD_STAGES + 1)
);
    logic                      id_valid;
    logic [NUM_SRC*5-1:0]      id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [NUM_SRC-1:0]        id_early;
    logic [4:0]                id_rd;
    logic                      id_regwrite;
    logic                      id_is_load;
    logic                      pipe_stall;
    logic                      flush;
    logic                      hazard_stall;
    logic [NUM_SRC*SELW-1:0]   id_fwd_sel;
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
`ifdef FWD_PERF_EN
    logic [31:0]               stall_count;
`endif

    modport master (
        output id_valid, id_rs, id_rs_used, id_early, id_rd, id_regwrite, id_is_load,
               pipe_stall, flush,
        input  hazard_stall, id_fwd_sel, ex_fwd_sel
`ifdef FWD_PERF_EN
        , input stall_count
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_early, id_rd, id_regwrite, id_is_load,
               pipe_stall, flush,
        output hazard_stall, id_fwd_sel, ex_fwd_sel
`ifdef FWD_PERF_EN
        , output stall_count
`endif
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// Matches one source register against every tracked stage; youngest match wins.
// Latency: purely combinational.
// Backpressure: none; reports early/EX hazards for the parent to stall on.
// Ports: rs_i/used_i/early_i source info, stages_i shadow pipe, *_sel_o selects, *_hazard_o flags.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SELW             = $clog2(FWD_STAGES + 1)
) (
    input  logic [4:0]                   rs_i,
    input  logic                         used_i,
    input  logic                         early_i,
    input  stage_tag_t [FWD_STAGES-1:0]  stages_i,
    output logic [SELW-1:0]              early_sel_o,
    output logic [SELW-1:0]              ex_sel_o,
    output logic                         early_hazard_o,
    output logic                         ex_hazard_o
);
    logic found;
    logic found_load;
    int   idx;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        found      = 1'b0;
        found_load = 1'b0;
        idx        = 0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (used_i && stages_i[k].valid && stages_i[k].regwrite &&
                stages_i[k].rd != REG_ZERO && stages_i[k].rd == rs_i) begin
                found      = 1'b1;
                found_load = stages_i[k].is_load;
                idx        = k;
            end
        end
    end

    always_comb begin
        early_sel_o    = SELW'(FWD_SEL_RF);
        ex_sel_o       = SELW'(FWD_SEL_RF);
        early_hazard_o = 1'b0;
        ex_hazard_o    = 1'b0;
        if (found) begin
            early_sel_o    = SELW'(idx + 1);
            // By EX the producer has moved one stage on; past the last tracked
            // stage it has written the register file, which reads through.
            ex_sel_o       = (idx + 1 < FWD_STAGES) ? SELW'(idx + 2) : SELW'(FWD_SEL_RF);
            early_hazard_o = early_i & ~tag_ready(found_load, idx, LOAD_READY_STAGE);
            ex_hazard_o    = ~tag_ready(found_load, idx + 1, LOAD_READY_STAGE);
        end
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand-hazard controller: shadow pipe of destination tags, bypass selects, load/early-use stall.
// Latency: hazard_stall and id_fwd_sel combinational; ex_fwd_sel registered on issue (1 cycle).
// Backpressure: hazard_stall holds ID and inserts a bubble; pipe_stall freezes all state.
// Ports: clk, rst_n (async active-low), bus (slave modport of hazard_forward_ctrl_if).
// Optional: FWD_PERF_EN adds the stall_count cycle counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int FWD_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SELW             = $clog2(FWD_STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);
    stage_tag_t [FWD_STAGES-1:0] stage_q, stage_d;
    logic [NUM_SRC*SELW-1:0]     ex_sel_q, ex_sel_d;
    logic [NUM_SRC*SELW-1:0]     ex_sel_c;
    logic [NUM_SRC-1:0]          early_hz, ex_hz;
    logic                        issue;
    stage_tag_t                  new_tag;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .FWD_STAGES      (FWD_STAGES),
            .LOAD_READY_STAGE(LOAD_READY_STAGE),
            .SELW            (SELW)
        ) u_match (
            .rs_i          (bus.id_rs[5*i +: 5]),
            .used_i        (bus.id_rs_used[i]),
            .early_i       (bus.id_early[i]),
            .stages_i      (stage_q),
            .early_sel_o   (bus.id_fwd_sel[SELW*i +: SELW]),
            .ex_sel_o      (ex_sel_c[SELW*i +: SELW]),
            .early_hazard_o(early_hz[i]),
            .ex_hazard_o   (ex_hz[i])
        );
    end

    assign bus.hazard_stall = bus.id_valid & ~bus.flush & (|(early_hz | ex_hz));
    assign issue            = bus.id_valid & ~bus.hazard_stall & ~bus.flush;
    assign bus.ex_fwd_sel   = ex_sel_q;

    always_comb begin
        new_tag          = '0;
        new_tag.valid    = 1'b1;
        new_tag.rd       = bus.id_rd;
        new_tag.regwrite = bus.id_regwrite;
        new_tag.is_load  = bus.id_is_load;
    end

    always_comb begin
        stage_d  = stage_q;
        ex_sel_d = ex_sel_q;
        if (!bus.pipe_stall) begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                stage_d[k] = stage_q[k-1];
            end
            stage_d[0] = issue ? new_tag : '0;
            ex_sel_d   = issue ? ex_sel_c : '0;
        end else if (bus.flush) begin
            // Frozen pipe: a flush only kills whatever sits in stage 0.
            stage_d[0].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q  <= '0;
            ex_sel_q <= '0;
        end else begin
            stage_q  <= stage_d;
            ex_sel_q <= ex_sel_d;
        end
    end

`ifdef FWD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.hazard_stall && !bus.pipe_stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: per-cycle stimulus with expected EX selects queued.
// Latency: combinational outputs checked mid-cycle, ex_fwd_sel checked after the following edge.
// Backpressure: exercises hazard_stall, pipe_stall and flush interaction.
module tb_hazard_forward_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [3:0] exp_q[$];

    hazard_forward_ctrl_if #(.NUM_SRC(2), .FWD_STAGES(3), .SELW(2)) bus ();

    hazard_forward_ctrl #(
        .NUM_SRC(2), .FWD_STAGES(3), .LOAD_READY_STAGE(2), .SELW(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Entered at posedge+1: drive, check combinational outputs at negedge,
    // queue the EX select expected after the edge, then pop and compare it.
    task automatic cyc(input string tag, input bit v, input int rs1, input int rs2,
                       input bit [1:0] used, input bit [1:0] early, input int rd,
                       input bit rw, input bit ld, input bit ps, input bit fl,
                       input bit exp_hz, input bit [3:0] exp_id, input bit [3:0] exp_ex);
        logic [3:0] e;
        bus.id_valid    = v;
        bus.id_rs       = {5'(rs2), 5'(rs1)};
        bus.id_rs_used  = used;
        bus.id_early    = early;
        bus.id_rd       = 5'(rd);
        bus.id_regwrite = rw;
        bus.id_is_load  = ld;
        bus.pipe_stall  = ps;
        bus.flush       = fl;
        @(negedge clk);
        check_val({tag, "_hz"}, 32'(bus.hazard_stall), 32'(exp_hz));
        check_val({tag, "_id"}, 32'(bus.id_fwd_sel), 32'(exp_id));
        exp_q.push_back(exp_ex);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_ex_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_ex"}, 32'(bus.ex_fwd_sel), 32'(e));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rs_used = '0; bus.id_early = '0;
        bus.id_rd = '0; bus.id_regwrite = 0; bus.id_is_load = 0;
        bus.pipe_stall = 0; bus.flush = 0;
        #3;
        check_val("rst_hz", 32'(bus.hazard_stall), 32'd0);
        check_val("rst_id", 32'(bus.id_fwd_sel), 32'd0);
        check_val("rst_ex", 32'(bus.ex_fwd_sel), 32'd0);
`ifdef FWD_PERF_EN
        check_val("rst_cnt", bus.stall_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //      tag      v rs1 rs2 used  early rd rw ld ps fl hz id      ex
        // ALU producer then EX consumer: forwarded from MEM.
        cyc("alu_p",  1, 1,  2,  2'b11, 2'b00, 5, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("alu_c",  1, 5,  3,  2'b11, 2'b00, 8, 1, 0, 0, 0, 0, 4'b0001, 4'b0010);
        // Load-use in EX: one bubble, then WB forward.
        cyc("ld6_p",  1, 1,  0,  2'b01, 2'b00, 6, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("ld6_s",  1, 6,  0,  2'b01, 2'b00, 10, 1, 0, 0, 0, 1, 4'b0001, 4'b0000);
        cyc("ld6_i",  1, 6,  0,  2'b01, 2'b00, 10, 1, 0, 0, 0, 0, 4'b0010, 4'b0011);
        // Load then early (jalr) use: two bubbles, then id select = WB.
        cyc("ld7_p",  1, 0,  0,  2'b00, 2'b00, 7, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("jr_s1",  1, 7,  0,  2'b01, 2'b01, 1, 1, 0, 0, 0, 1, 4'b0001, 4'b0000);
        cyc("jr_s2",  1, 7,  0,  2'b01, 2'b01, 1, 1, 0, 0, 0, 1, 4'b0010, 4'b0000);
        cyc("jr_i",   1, 7,  0,  2'b01, 2'b01, 1, 1, 0, 0, 0, 0, 4'b0011, 4'b0000);
        // x0 is never forwarded.
        cyc("x0_p",   1, 0,  0,  2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("x0_c",   1, 0,  0,  2'b11, 2'b01, 13, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        // Load reading x13 (forwarded), then a load-use stall frozen by pipe_stall.
        cyc("ld11_p", 1, 13, 0,  2'b01, 2'b00, 11, 1, 1, 0, 0, 0, 4'b0001, 4'b0010);
        cyc("frz1",   1, 11, 0,  2'b01, 2'b00, 12, 1, 0, 1, 0, 1, 4'b0001, 4'b0010);
        cyc("frz2",   1, 11, 0,  2'b01, 2'b00, 12, 1, 0, 1, 0, 1, 4'b0001, 4'b0010);
        cyc("frz3",   1, 11, 0,  2'b01, 2'b00, 12, 1, 0, 1, 0, 1, 4'b0001, 4'b0010);
        cyc("frz_s",  1, 11, 0,  2'b01, 2'b00, 12, 1, 0, 0, 0, 1, 4'b0001, 4'b0000);
        cyc("frz_i",  1, 11, 0,  2'b01, 2'b00, 12, 1, 0, 0, 0, 0, 4'b0010, 4'b0011);
        // Two producers of x9: youngest (stage 0) wins.
        cyc("x9_a",   1, 0,  0,  2'b00, 2'b00, 9, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("x9_b",   1, 0,  0,  2'b00, 2'b00, 9, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("x9_c",   1, 9,  0,  2'b01, 2'b00, 14, 1, 0, 0, 0, 0, 4'b0001, 4'b0010);
        // Flush masks a load-use hazard and inserts a bubble.
        cyc("ld15_p", 1, 0,  0,  2'b00, 2'b00, 15, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("fl_c",   1, 15, 0,  2'b01, 2'b00, 20, 1, 0, 0, 1, 0, 4'b0001, 4'b0000);
        cyc("fl_i",   1, 15, 0,  2'b01, 2'b00, 20, 1, 0, 0, 0, 0, 4'b0010, 4'b0011);
        // Flush during pipe_stall clears only stage 0 (the x17 load disappears).
        cyc("ld17_p", 1, 0,  0,  2'b00, 2'b00, 17, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("psfl",   1, 17, 0,  2'b01, 2'b00, 21, 1, 0, 1, 1, 0, 4'b0001, 4'b0000);
        cyc("psfl_a", 1, 17, 0,  2'b01, 2'b00, 21, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
`ifdef FWD_PERF_EN
        check_val("stall_cnt", bus.stall_count, 32'd4);
`endif

        // Async reset in the middle of a load-use stall.
        cyc("ld16_p", 1, 0,  0,  2'b00, 2'b00, 16, 1, 1, 0, 0, 0, 4'b0000, 4'b0000);
        bus.id_rs = {5'd0, 5'd16}; bus.id_rs_used = 2'b01; bus.id_early = 2'b00;
        bus.id_rd = 5'd22; bus.id_is_load = 0;
        #2;
        check_val("arst_pre_hz", 32'(bus.hazard_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_hz", 32'(bus.hazard_stall), 32'd0);
        check_val("arst_id", 32'(bus.id_fwd_sel), 32'd0);
        check_val("arst_ex", 32'(bus.ex_fwd_sel), 32'd0);
`ifdef FWD_PERF_EN
        check_val("arst_cnt", bus.stall_count, 32'd0);
`endif
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        #4;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised operand-hazard controller for the pipelined RISC-V core, sitting beside the ID stage. It keeps its own shadow pipeline of in-flight destination tags, one entry per forwarding stage. From that pipeline it computes per-source bypass selects for EX-stage consumers and for ID-stage ("early", jalr/branch) consumers. It also raises a load-use/early-use stall and registers the EX bypass selects into the ID/EX boundary.

## Interface
Parameters:
- NUM_SRC, 2: number of source operands per instruction.
- FWD_STAGES, 3: tracked stages after ID (index 0 = EX, 1 = MEM, 2 = WB, ...); must be at least 2.
- LOAD_READY_STAGE, 2: first stage index at which a load result is forwardable.
- SELW, $clog2(FWD_STAGES+1): select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  valid instruction in ID.
- id_rs  in  NUM_SRC*5  source register numbers; source i is at [5i+4:5i].
- id_rs_used  in  NUM_SRC  source i is actually read.
- id_early  in  NUM_SRC  source i is consumed in ID (jalr base, ID-resolved branch).
- id_rd  in  5  destination register.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- pipe_stall  in  1  external freeze (cache miss etc.).
- flush  in  1  squash the ID instruction.
- hazard_stall  out  1  combinational; hold ID, insert bubble.
- id_fwd_sel  out  NUM_SRC*SELW  combinational early-use select: 0 = register file, k+1 = stage k.
- ex_fwd_sel  out  NUM_SRC*SELW  registered EX-use select: 0 = register file, k+1 = stage k.
- stall_count  out  32  hazard stall cycle count; present only with FWD_PERF_EN.

## Operation
- Each stage entry holds {valid, rd, regwrite, is_load}.
- A producer matches a source iff the entry is valid, regwrite=1, rd!=0 and rd==rs, and the source is id_rs_used.
- When several stages match, the youngest (lowest index) wins.
- Readiness: an ALU producer is ready at stage index ≥1; a load producer is ready at index ≥LOAD_READY_STAGE.
- Early source: a producer matching at stage k must be ready at k, otherwise hazard_stall. id_fwd_sel = k+1; 0 if no match.
- EX source: the producer will sit at stage k+1 when the consumer reaches EX, and must be ready at k+1, otherwise hazard_stall.
  - Registered select = k+2 if k+1 < FWD_STAGES, else 0 (register file, write-through).
- hazard_stall = id_valid & ~flush & OR over all source hazards.
- Advance (pipe_stall=0): stage k+1 ← stage k.
  - Stage 0 ← ID tags if id_valid & ~hazard_stall & ~flush; otherwise a bubble (valid=0).
- ex_fwd_sel loads the computed EX selects on issue, and loads 0 on a bubble.
- pipe_stall=1 freezes all entries and ex_fwd_sel. If flush is also 1, only the stage-0 valid is cleared. The ID instruction is never captured while pipe_stall=1.

## Timing
- Reset: all entry valid=0, ex_fwd_sel=0, stall_count=0. Outputs therefore read hazard_stall=0 and id_fwd_sel=0.
- hazard_stall and id_fwd_sel have zero latency (same cycle as the ID inputs).
- ex_fwd_sel is valid in the cycle after issue, aligned with the consumer's EX cycle.
- Stall lengths with defaults:
  - EX use behind a load: 1 cycle.
  - Early use behind an ALU op: 1 cycle.
  - Early use behind a load: 2 cycles.
- Reset asserted mid-stall clears all entries at once; hazard_stall deasserts asynchronously.

## Configuration
- FWD_PERF_EN defined: stall_count increments on every cycle with hazard_stall=1 and pipe_stall=0. It wraps at 2^32−1 → 0.
- FWD_PERF_EN undefined: the stall_count port and its counter are absent.

## Structure
- Shared package hazard_pkg:
  - stage_tag_t struct {valid, rd[4:0], regwrite, is_load}.
  - FWD_SEL_RF = 0 constant.
  - REG_ZERO = 5'd0.
- Sub-module fwd_match: one source against all stages, returning the youngest-match select plus ex_hazard and early_hazard. It is instantiated NUM_SRC times.

## Test plan
- ALU `add x5` issued, next instruction reads x5 in EX → hazard_stall=0; ex_fwd_sel for that source = 2 (MEM) in the consumer's EX cycle.
- Load x6, then an immediate EX use of x6 → hazard_stall=1 for exactly 1 cycle; after issue, ex_fwd_sel = 3 (WB).
- Load x7, then jalr with early rs1=x7 → hazard_stall for 2 cycles; then id_fwd_sel = 3 and the jalr issues.
- Producer with rd=x0 and regwrite=1, consumer reads x0 → no stall, all selects 0.
- pipe_stall=1 for 3 cycles during a load-use stall → entries and ex_fwd_sel frozen; the stall resolves 1 cycle after pipe_stall drops. With FWD_PERF_EN, stall_count = 1.
- Two matching producers (stage 0 and stage 1, both writing x9) → youngest wins (ex_fwd_sel = 2). flush in the same cycle → stage 0 gets a bubble and hazard_stall=0.
